logic_updown_counter_n: RTL and testbench
=========================================

Name: logic_updown_counter_n

Overview:
- Parametrised synchronous up/down binary counter; successor to the 4-bit '191-style counter in the logic library.
- Adds configurable width and modulus, synchronous reset, a cascade-friendly ripple-carry output and a sticky overflow flag with clear.
- Used by emulator timing, prescaler and address-sequencing logic wherever a cascadable up/down counter with arbitrary modulus is needed.

Parameters:
- WIDTH, 4, counter and data width in bits (2..32).
- MODULUS, 16, count modulus; legal values are 2..2^WIDTH; terminal values are 0 and MODULUS-1.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- MR  input  1  synchronous reset, active-high.
- nCE  input  1  count enable, active-low.
- nUD  input  1  direction; 0 = up, 1 = down.
- nPL  input  1  synchronous parallel load, active-low.
- D  input  WIDTH  parallel load data.
- CLR_OVF  input  1  clears sticky OVF, active-high.
- Q  output  WIDTH  counter value, registered.
- TC  output  1  terminal count, combinational from Q and nUD.
- nRC  output  1  ripple carry, active-low; feeds nCE of the next stage.
- OVF  output  1  sticky wrap flag, registered.

Behaviour:
- Reset (MR=1 at a CP rising edge): Q=0, OVF=0. MR overrides all other inputs. The outputs after reset are: TC=1 if nUD=1, else TC=(MODULUS-1==0)=0; nRC follows its equation.
- Priority per edge: MR > nPL load > count > hold.
- Load (nPL=0): Q <= D if D < MODULUS, else Q <= MODULUS-1. The load ignores nCE and nUD. OVF is unchanged. Latency is 1 cycle.
- Count (nPL=1, nCE=0):
  - Up (nUD=0): Q <= Q+1. If Q==MODULUS-1, Q <= 0 instead.
  - Down (nUD=1): Q <= Q-1. If Q==0, Q <= MODULUS-1 instead.
- Hold (nCE=1): Q unchanged.
- Arithmetic is in WIDTH bits. There is no intermediate overflow when MODULUS=2^WIDTH; the natural wrap equals the modulus wrap.
- TC: up mode TC=(Q==MODULUS-1); down mode TC=(Q==0). TC responds to nUD combinationally in the same cycle.
- nRC = ~(~nCE & TC). It goes low in the cycle before a wrap, so the next stage counts on the same edge as this stage wraps. There is no clock gating and no glitch path through CP.
- OVF set condition: a count edge where TC=1 (a wrap or terminal hit). OVF then stays 1 until MR, or until CLR_OVF=1 at a rising edge.
- OVF simultaneous events: if CLR_OVF=1 and a wrap occur on the same edge, OVF=1 (set wins). CLR_OVF has no effect on Q.
- Load at the terminal value: no OVF. Loading MODULUS-1 in up mode makes TC=1 on the next cycle.
- Direction change mid-count: takes effect on the next edge. No extra step, no skipped value.
- Reset mid-load or mid-count: reset wins; D is discarded.
- Out-of-range parameters (MODULUS < 2 or > 2^WIDTH): an elaboration-time error via a generate-time check.

Optional Feature:
- Macro: LOGIC_UDCNT_SATURATE_EN
- Defined: the counter saturates instead of wrapping.
  - Up mode holds at MODULUS-1; down mode holds at 0.
  - OVF sets on the first count edge attempted while TC=1.
  - nRC still asserts while TC=1 and nCE=0, so the next stage keeps counting.
  - Load behaviour is unchanged.
- Undefined: wrap behaviour as described in Behaviour. The saturation logic is absent from the netlist.

Test Plan:
- Reset/basic up: WIDTH=4, MODULUS=10; MR=1 for 1 cycle, then nCE=0, nUD=0 for 12 edges -> Q=0,1,..,9,0,1. TC=1 and nRC=0 only while Q=9. OVF=1 from the edge where 9->0.
- Down wrap and clear: WIDTH=4, MODULUS=10; load D=2, nUD=1, count 4 edges -> Q=1,0,9,8. OVF sets on 0->9. CLR_OVF=1 on one edge with no wrap -> OVF=0. CLR_OVF on the same edge as a wrap -> OVF stays 1.
- Load priority and clamp: WIDTH=4, MODULUS=10; nPL=0, nCE=0, D=4'hC -> Q=9, OVF unchanged. Then nPL=0 with MR=1 on the same edge -> Q=0.
- Cascade: two instances, WIDTH=4, MODULUS=16; low stage nRC drives high stage nCE; count up from 8'h0E for 3 edges -> combined value 0F, 10, 11. High-stage OVF stays 0.
- Hold and direction flip: WIDTH=8, MODULUS=256; Q=8'hFF, nUD=0, nCE=1 -> Q holds 8'hFF, TC=1, nRC=1. Set nUD=1 -> TC=0 in the same cycle. nCE=0 for one edge -> Q=8'hFE.
- Saturate (LOGIC_UDCNT_SATURATE_EN defined): WIDTH=4, MODULUS=10, Q=8, up, 3 edges -> Q=9, 9, 9. OVF sets on the second edge.

Source files
------------

// File: rtl/logic_updown_counter_n.sv
// Parametrised synchronous up/down counter with modulus, ripple carry and sticky OVF.
// Optional build macro LOGIC_UDCNT_SATURATE_EN: saturate at the terminal value instead of wrapping.
module logic_updown_counter_n #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             nCE,
    input  logic             nUD,
    input  logic             nPL,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             nRC,
    output logic             OVF
);

    localparam longint           MOD_MAX = longint'(1) << WIDTH;
    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH - 1){1'b0}}, 1'b1};

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("logic_updown_counter_n: WIDTH must be 2..32");
        end
        if (MODULUS < 2 || MODULUS > MOD_MAX) begin : g_bad_modulus
            $error("logic_updown_counter_n: MODULUS must be 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             tc;
    logic             count_edge;
    logic             d_in_range;

    // Terminal value depends on direction, so TC follows nUD without waiting for an edge.
    assign tc         = nUD ? (q_q == '0) : (q_q == TERM);
    assign count_edge = nPL & ~nCE;
    assign d_in_range = {1'b0, D} < MOD_EXT;

    always_comb begin
        q_d = q_q;
        // NOTE: reset is synchronous, so it is just the highest-priority term of the next-state logic.
        if (MR) begin
            q_d = '0;
        end else if (!nPL) begin
            q_d = d_in_range ? D : TERM;
        end else if (!nCE) begin
`ifdef LOGIC_UDCNT_SATURATE_EN
            if (!tc) begin
                q_d = nUD ? (q_q - ONE) : (q_q + ONE);
            end
`else
            if (tc) begin
                q_d = nUD ? TERM : '0;
            end else begin
                q_d = nUD ? (q_q - ONE) : (q_q + ONE);
            end
`endif
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (MR) begin
            ovf_d = 1'b0;
        end else if (count_edge && tc) begin
            ovf_d = 1'b1;   // a wrap on the clear edge must not be lost
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
    always_ff @(posedge CP) begin
        q_q   <= q_d;
        ovf_q <= ovf_d;
    end

    assign Q   = q_q;
    assign TC  = tc;
    assign nRC = ~(~nCE & tc);
    assign OVF = ovf_q;

endmodule

// File: tb/tb_logic_updown_counter_n.sv
// Scoreboard bench for logic_updown_counter_n: directed scenarios plus random stimulus,
// checked against an arithmetic reference model for four instances (incl. a two-stage cascade).
module tb_logic_updown_counter_n;

    typedef struct {
        longint unsigned q;
        logic            ovf;
    } st_t;

    typedef struct {
        longint unsigned qa;  logic oa; logic tca; logic nrca;
        longint unsigned ql;  longint unsigned qh; logic ol; logic oh; logic nrcl;
        longint unsigned qc;  logic oc; logic tcc; logic nrcc;
    } exp_t;

    logic       CP = 1'b0;
    logic       mr, clr;
    logic       a_nce, a_npl, a_nud;  logic [3:0] a_d;
    logic       k_nce, k_npl, k_nud;  logic [3:0] kl_d, kh_d;
    logic       c_nce, c_npl, c_nud;  logic [7:0] c_d;

    logic [3:0] a_q, l_q, h_q;
    logic [7:0] c_q;
    logic       a_tc, a_nrc, a_ovf, l_tc, l_nrc, l_ovf, h_tc, h_nrc, h_ovf, c_tc, c_nrc, c_ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    st_t  sa, sl, sh, sc;

    always #5 CP = ~CP;

    logic_updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut_a (
        .CP(CP), .MR(mr), .nCE(a_nce), .nUD(a_nud), .nPL(a_npl), .D(a_d), .CLR_OVF(clr),
        .Q(a_q), .TC(a_tc), .nRC(a_nrc), .OVF(a_ovf));

    logic_updown_counter_n #(.WIDTH(4), .MODULUS(16)) dut_l (
        .CP(CP), .MR(mr), .nCE(k_nce), .nUD(k_nud), .nPL(k_npl), .D(kl_d), .CLR_OVF(clr),
        .Q(l_q), .TC(l_tc), .nRC(l_nrc), .OVF(l_ovf));

    logic_updown_counter_n #(.WIDTH(4), .MODULUS(16)) dut_h (
        .CP(CP), .MR(mr), .nCE(l_nrc), .nUD(k_nud), .nPL(k_npl), .D(kh_d), .CLR_OVF(clr),
        .Q(h_q), .TC(h_tc), .nRC(h_nrc), .OVF(h_ovf));

    logic_updown_counter_n #(.WIDTH(8), .MODULUS(256)) dut_c (
        .CP(CP), .MR(mr), .nCE(c_nce), .nUD(c_nud), .nPL(c_npl), .D(c_d), .CLR_OVF(clr),
        .Q(c_q), .TC(c_tc), .nRC(c_nrc), .OVF(c_ovf));

    function automatic logic tc_of(longint unsigned q, longint unsigned m, logic nud);
        return nud ? (q == 0) : (q == m - 1);
    endfunction

    // Reference behaviour of one counter over one rising edge.
    function automatic st_t step(st_t s, longint unsigned m, logic r, logic npl, logic nce,
                                 logic nud, logic c, longint unsigned d);
        st_t  n = s;
        logic t = tc_of(s.q, m, nud);
        if (r) begin
            n.q   = 0;
            n.ovf = 1'b0;
        end else begin
            if (!npl) begin
                n.q = (d < m) ? d : m - 1;
            end else if (!nce) begin
`ifdef LOGIC_UDCNT_SATURATE_EN
                if (!t) n.q = nud ? s.q - 1 : s.q + 1;
`else
                n.q = nud ? (s.q + m - 1) % m : (s.q + 1) % m;
`endif
            end
            if (npl && !nce && t) n.ovf = 1'b1;
            else if (c)           n.ovf = 1'b0;
        end
        return n;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Computes the expected result of the coming edge, queues it, then waits for the next falling edge.
    task automatic issue();
        exp_t e;
        logic nrcl_pre;
        st_t  na, nl, nh, nc;
        nrcl_pre = ~(~k_nce & tc_of(sl.q, 16, k_nud));
        na = step(sa, 10,  mr, a_npl, a_nce,    a_nud, clr, a_d);
        nl = step(sl, 16,  mr, k_npl, k_nce,    k_nud, clr, kl_d);
        nh = step(sh, 16,  mr, k_npl, nrcl_pre, k_nud, clr, kh_d);
        nc = step(sc, 256, mr, c_npl, c_nce,    c_nud, clr, c_d);
        e.qa = na.q; e.oa = na.ovf; e.tca = tc_of(na.q, 10, a_nud);
        e.nrca = ~(~a_nce & e.tca);
        e.ql = nl.q; e.qh = nh.q; e.ol = nl.ovf; e.oh = nh.ovf;
        e.nrcl = ~(~k_nce & tc_of(nl.q, 16, k_nud));
        e.qc = nc.q; e.oc = nc.ovf; e.tcc = tc_of(nc.q, 256, c_nud);
        e.nrcc = ~(~c_nce & e.tcc);
        sb.push_back(e);
        sa = na; sl = nl; sh = nh; sc = nc;
        @(negedge CP);
    endtask

    task automatic idle();
        mr = 1'b0; clr = 1'b0;
        a_nce = 1'b1; a_npl = 1'b1;
        k_nce = 1'b1; k_npl = 1'b1;
        c_nce = 1'b1; c_npl = 1'b1;
    endtask

    // Monitor: outputs settle just after each rising edge; compare against the oldest queued entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CP);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("a_q",    a_q,   e.qa);   check("a_ovf", a_ovf, e.oa);
                check("a_tc",   a_tc,  e.tca);  check("a_nrc", a_nrc, e.nrca);
                check("casc_q", {h_q, l_q}, (e.qh << 4) | e.ql);
                check("l_ovf",  l_ovf, e.ol);   check("h_ovf", h_ovf, e.oh);
                check("l_nrc",  l_nrc, e.nrcl);
                check("c_q",    c_q,   e.qc);   check("c_ovf", c_ovf, e.oc);
                check("c_tc",   c_tc,  e.tcc);  check("c_nrc", c_nrc, e.nrcc);
            end
        end
    end

    initial begin : stimulus
        sa = '{0, 1'b0}; sl = '{0, 1'b0}; sh = '{0, 1'b0}; sc = '{0, 1'b0};
        idle();
        mr = 1'b1;
        a_nud = 1'b0; a_d = '0; k_nud = 1'b0; kl_d = '0; kh_d = '0; c_nud = 1'b0; c_d = '0;
        @(negedge CP);

        // Reset, then count up through the wrap
        issue();
        mr = 1'b0; a_nud = 1'b0; a_nce = 1'b0;
        repeat (12) issue();

        // Load 2, count down across 0, clear OVF on a plain edge, then on a wrap edge
        a_npl = 1'b0; a_d = 4'd2; a_nud = 1'b1; issue();
        a_npl = 1'b1; repeat (4) issue();
        clr = 1'b1; issue(); clr = 1'b0;
        repeat (7) issue();
        clr = 1'b1; issue(); clr = 1'b0;

        // Out-of-range load clamps; reset beats a simultaneous load
        a_npl = 1'b0; a_nce = 1'b0; a_d = 4'hC; issue();
        mr = 1'b1; a_d = 4'd5; issue();
        mr = 1'b0; a_npl = 1'b1; a_nce = 1'b1;

        // Approach the terminal value from 8 going up (wraps or saturates depending on build)
        a_npl = 1'b0; a_d = 4'd8; issue();
        a_npl = 1'b1; a_nud = 1'b0; a_nce = 1'b0;
        repeat (3) issue();
        a_nce = 1'b1;

        // Two-stage cascade from 8'h0E
        k_nud = 1'b0; k_npl = 1'b0; kl_d = 4'hE; kh_d = 4'h0; issue();
        k_npl = 1'b1; k_nce = 1'b0;
        repeat (3) issue();
        k_nce = 1'b1;

        // Hold at 8'hFF, flip direction between edges, then one down step
        c_npl = 1'b0; c_d = 8'hFF; c_nud = 1'b0; issue();
        c_npl = 1'b1; issue();
        c_nud = 1'b1;
        #1 check("c_tc_flip", c_tc, tc_of(sc.q, 256, 1'b1));
        issue();
        c_nce = 1'b0; issue();
        c_nce = 1'b1;

        // Random traffic on every instance
        for (int i = 0; i < 400; i++) begin
            mr    = ($urandom_range(0, 39) == 0);
            clr   = ($urandom_range(0, 5) == 0);
            a_npl = ($urandom_range(0, 7) != 0); a_nce = ($urandom_range(0, 3) == 0);
            a_nud = 1'($urandom);                a_d   = 4'($urandom);
            k_npl = ($urandom_range(0, 15) != 0); k_nce = ($urandom_range(0, 3) == 0);
            k_nud = 1'($urandom);                 kl_d  = 4'($urandom); kh_d = 4'($urandom);
            c_npl = ($urandom_range(0, 7) != 0); c_nce = ($urandom_range(0, 3) == 0);
            c_nud = 1'($urandom);                c_d   = 8'($urandom);
            issue();
        end
        idle();

        repeat (2) @(negedge CP);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
